fcp_credit_tx_gate: RTL and testbench
=====================================

FCP_CREDIT_TX_GATE -- requirements
Module: fcp_credit_tx_gate

Interface
REQ-001 SHALL take parameter QUEUE_INDEX_WIDTH, default 4, as the VC index width (2**QUEUE_INDEX_WIDTH VCs).
REQ-002 SHALL take parameter DATA_WIDTH, default 64, as the AXI-Stream data width.
REQ-003 SHALL take parameter STAT_WIDTH, default 32, as the credit counter and statistic width.
REQ-004 SHALL take parameter INIT_CREDIT, default 16, as the per-VC credit limit loaded at reset, in beats.
REQ-005 SHALL have clk, input, 1 bit: the single clock.
REQ-006 SHALL have rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have s_axis_pkt_tdata/tvalid/tlast/tkeep, inputs, DATA_WIDTH/1/1/DATA_WIDTH/8 bits: upstream packet stream; VC = tdata[16 +: QUEUE_INDEX_WIDTH] on the head beat.
REQ-008 SHALL have s_axis_pkt_tready, output, 1 bit: upstream accept.
REQ-009 SHALL have m_axis_pkt_tdata/tvalid/tlast/tkeep, outputs, same widths: stream to the downstream switch model.
REQ-010 SHALL have m_axis_pkt_tready, input, 1 bit: downstream accept.
REQ-011 SHALL have fcp_valid (input, 1), fcp_vc (input, QUEUE_INDEX_WIDTH) and fcp_fccl (input, STAT_WIDTH): FCP credit-limit update from downstream.
REQ-012 SHALL have dbg_tx_beat_count, dbg_credit_stall_count and dbg_fcp_stale_count, outputs, STAT_WIDTH each.

Function
REQ-013 SHALL hold per-VC registers FCCL[v] (credit limit) and FCTBS[v] (total beats sent), each STAT_WIDTH wide and wrapping mod 2**STAT_WIDTH.
REQ-014 SHALL compute avail = (FCCL[vc] - FCTBS[vc]) mod 2**STAT_WIDTH; credit_ok SHALL be true iff avail != 0 and avail MSB == 0.
REQ-015 SHALL implement a two-state FSM, S_HEAD and S_BODY; in S_HEAD vc SHALL be parsed from s_axis_pkt_tdata, and in S_BODY vc SHALL be the latched vc_reg.
REQ-016 SHALL drive s_axis_pkt_tready = credit_ok AND (m_axis_pkt_tready OR NOT m_axis_pkt_tvalid), combinationally.
REQ-017 SHALL, on an accepted beat, register tdata/tlast/tkeep into the output stage, set m_axis_pkt_tvalid the next cycle (1-cycle latency), and increment FCTBS[vc] and dbg_tx_beat_count by 1.
REQ-018 SHALL make the FSM transition S_HEAD->S_BODY (latching vc_reg) on an accepted head beat with tlast=0, and S_BODY->S_HEAD on an accepted beat with tlast=1.
REQ-019 SHALL treat an accepted single-beat packet (tlast=1 in S_HEAD) as remaining in S_HEAD.
REQ-020 SHALL clear m_axis_pkt_tvalid on a downstream handshake when no new beat is accepted in the same cycle.
REQ-021 SHALL hold the output registers stable while m_axis_pkt_tvalid=1 and m_axis_pkt_tready=0.
REQ-022 SHALL increment dbg_credit_stall_count in every cycle where s_axis_pkt_tvalid=1, credit_ok=0 and the output stage can accept.
REQ-023 SHALL, on fcp_valid, write FCCL[fcp_vc] = fcp_fccl if (fcp_fccl - FCCL[fcp_vc]) mod 2**STAT_WIDTH has MSB 0; otherwise it SHALL discard the update and increment dbg_fcp_stale_count.
REQ-024 SHALL make an FCP update and a send in the same cycle (same or different VC) both take effect; credit_ok in that cycle SHALL use the pre-update FCCL.
REQ-025 SHALL allow a mid-packet credit stall: the packet pauses in S_BODY and resumes without reordering.
REQ-026 SHALL let every statistic counter wrap mod 2**STAT_WIDTH.

Reset
REQ-027 SHALL, on rst, asynchronously set FCCL[v]=INIT_CREDIT and FCTBS[v]=0 for all v, set the FSM to S_HEAD, and set vc_reg=0.
REQ-028 SHALL, on rst, asynchronously set m_axis_pkt_tvalid/tdata/tlast/tkeep=0 and all dbg counters=0; s_axis_pkt_tready SHALL evaluate to 1 after reset with INIT_CREDIT>0.
REQ-029 SHALL, if rst occurs mid-packet, discard the partial packet state; no recovery of the truncated packet is required.

Verification
REQ-030 SHALL verify credit exhaustion (INIT_CREDIT=4): 6 single-beat packets to VC0 with m_tready=1 -> 4 forwarded, then tready=0 with stall count rising; then FCP vc0 fccl=6 -> 2 more forwarded, FCTBS[0]=6, tx count=6.
REQ-031 SHALL verify stale FCP: fccl vc3=10, then fccl vc3=8 -> second update ignored, stale count=1, 10 beats on VC3 forwarded.
REQ-032 SHALL verify a mid-packet stall: with FCTBS[2]=2 and FCCL[2]=4, send a 3-beat VC2 packet whose later beats carry VC field 7 -> 2 beats pass, stall, FCP vc2 fccl=5 -> last beat passes, all counted on VC2, FCTBS[7]=0.
REQ-033 SHALL verify backpressure: m_tready=0 for 5 cycles with an output beat held -> output data unchanged, at most 1 beat accepted, FCTBS incremented only per accepted beat.
REQ-034 SHALL verify wrap (STAT_WIDTH=8, INIT_CREDIT=4): 300 beats on VC1 with FCP fccl advanced mod 256 -> all 300 forwarded in order, stale count=0, tx count=44 (300 mod 256).
REQ-035 SHALL verify reset mid-packet: rst during S_BODY -> outputs 0 immediately, and the next head beat is parsed for VC with credits reset to INIT_CREDIT.

Source files
------------

// File: rtl/fcp_credit_tx_gate.sv
// Credit-gated AXI-Stream transmit stage for FCP-style flow control.
// Each virtual channel (VC) keeps a credit limit (FCCL) and a count of
// beats sent (FCTBS). A beat is forwarded only while the VC has credit.
// The downstream side raises the limit with FCP updates. An update that
// would move the limit backwards is counted as stale and dropped.
//
// state  | meaning
// S_HEAD | next beat is a packet head; VC comes from tdata[16 +: QIW]
// S_BODY | inside a multi-beat packet; VC comes from the latched vc_reg
module fcp_credit_tx_gate #(
    parameter int QUEUE_INDEX_WIDTH = 4,
    parameter int DATA_WIDTH        = 64,
    parameter int STAT_WIDTH        = 32,
    parameter int INIT_CREDIT       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        s_axis_pkt_tdata,
    input  logic                         s_axis_pkt_tvalid,
    input  logic                         s_axis_pkt_tlast,
    input  logic [DATA_WIDTH/8-1:0]      s_axis_pkt_tkeep,
    output logic                         s_axis_pkt_tready,
    output logic [DATA_WIDTH-1:0]        m_axis_pkt_tdata,
    output logic                         m_axis_pkt_tvalid,
    output logic                         m_axis_pkt_tlast,
    output logic [DATA_WIDTH/8-1:0]      m_axis_pkt_tkeep,
    input  logic                         m_axis_pkt_tready,
    input  logic                         fcp_valid,
    input  logic [QUEUE_INDEX_WIDTH-1:0] fcp_vc,
    input  logic [STAT_WIDTH-1:0]        fcp_fccl,
    output logic [STAT_WIDTH-1:0]        dbg_tx_beat_count,
    output logic [STAT_WIDTH-1:0]        dbg_credit_stall_count,
    output logic [STAT_WIDTH-1:0]        dbg_fcp_stale_count
);

    localparam int NUM_VC     = 2 ** QUEUE_INDEX_WIDTH;
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam logic [STAT_WIDTH-1:0] ONE       = STAT_WIDTH'(1);
    localparam logic [STAT_WIDTH-1:0] INIT_CRED = STAT_WIDTH'(INIT_CREDIT);

    typedef enum logic {S_HEAD = 1'b0, S_BODY = 1'b1} state_t;

    state_t                         state_q, state_d;
    logic [QUEUE_INDEX_WIDTH-1:0]   vc_reg_q, vc_reg_d;
    logic [STAT_WIDTH-1:0]          fccl_q [NUM_VC];
    logic [STAT_WIDTH-1:0]          fccl_d [NUM_VC];
    logic [STAT_WIDTH-1:0]          fctbs_q [NUM_VC];
    logic [STAT_WIDTH-1:0]          fctbs_d [NUM_VC];
    logic [DATA_WIDTH-1:0]          tdata_q, tdata_d;
    logic                           tvalid_q, tvalid_d;
    logic                           tlast_q, tlast_d;
    logic [KEEP_WIDTH-1:0]          tkeep_q, tkeep_d;
    logic [STAT_WIDTH-1:0]          tx_cnt_q, tx_cnt_d;
    logic [STAT_WIDTH-1:0]          stall_cnt_q, stall_cnt_d;
    logic [STAT_WIDTH-1:0]          stale_cnt_q, stale_cnt_d;

    logic [QUEUE_INDEX_WIDTH-1:0]   vc;
    logic [STAT_WIDTH-1:0]          avail;
    logic [STAT_WIDTH-1:0]          fcp_delta;
    logic                           credit_ok;
    logic                           out_ready;
    logic                           beat_acc;

    // Credit check for the VC of the beat currently offered upstream.
    always_comb begin
        vc        = (state_q == S_BODY) ? vc_reg_q
                                        : s_axis_pkt_tdata[16 +: QUEUE_INDEX_WIDTH];
        avail     = fccl_q[vc] - fctbs_q[vc];
        credit_ok = (avail != '0) && !avail[STAT_WIDTH-1];
        out_ready = m_axis_pkt_tready || !tvalid_q;
    end

    // FSM outputs: upstream ready and the resulting beat handshake.
    always_comb begin
        s_axis_pkt_tready = credit_ok && out_ready;
        beat_acc          = s_axis_pkt_tvalid && s_axis_pkt_tready;
    end

    // FSM next state: the VC is latched only when a packet head opens a body.
    always_comb begin
        state_d  = state_q;
        vc_reg_d = vc_reg_q;
        if (beat_acc) begin
            case (state_q)
                S_HEAD: begin
                    if (!s_axis_pkt_tlast) begin
                        state_d  = S_BODY;
                        vc_reg_d = vc;
                    end
                end
                S_BODY: begin
                    if (s_axis_pkt_tlast) state_d = S_HEAD;
                end
                default: state_d = S_HEAD;
            endcase
        end
    end

    // Credit tables, output stage and statistics.
    // The credit check above reads the pre-update FCCL, so an FCP update in
    // the same cycle only affects the following cycles.
    always_comb begin
        fccl_d      = fccl_q;
        fctbs_d     = fctbs_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tkeep_d     = tkeep_q;
        tx_cnt_d    = tx_cnt_q;
        stall_cnt_d = stall_cnt_q;
        stale_cnt_d = stale_cnt_q;
        fcp_delta   = fcp_fccl - fccl_q[fcp_vc];

        if (beat_acc) begin
            tdata_d     = s_axis_pkt_tdata;
            tlast_d     = s_axis_pkt_tlast;
            tkeep_d     = s_axis_pkt_tkeep;
            tvalid_d    = 1'b1;
            fctbs_d[vc] = fctbs_q[vc] + ONE;
            tx_cnt_d    = tx_cnt_q + ONE;
        end else if (tvalid_q && m_axis_pkt_tready) begin
            tvalid_d = 1'b0;
        end

        if (s_axis_pkt_tvalid && !credit_ok && out_ready) begin
            stall_cnt_d = stall_cnt_q + ONE;
        end

        if (fcp_valid) begin
            if (!fcp_delta[STAT_WIDTH-1]) begin
                fccl_d[fcp_vc] = fcp_fccl;
            end else begin
                stale_cnt_d = stale_cnt_q + ONE;
            end
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_HEAD;
            vc_reg_q    <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tkeep_q     <= '0;
            tx_cnt_q    <= '0;
            stall_cnt_q <= '0;
            stale_cnt_q <= '0;
            for (int v = 0; v < NUM_VC; v++) begin
                fccl_q[v]  <= INIT_CRED;
                fctbs_q[v] <= '0;
            end
        end else begin
            state_q     <= state_d;
            vc_reg_q    <= vc_reg_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tkeep_q     <= tkeep_d;
            tx_cnt_q    <= tx_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            stale_cnt_q <= stale_cnt_d;
            fccl_q      <= fccl_d;
            fctbs_q     <= fctbs_d;
        end
    end

    assign m_axis_pkt_tdata       = tdata_q;
    assign m_axis_pkt_tvalid      = tvalid_q;
    assign m_axis_pkt_tlast       = tlast_q;
    assign m_axis_pkt_tkeep       = tkeep_q;
    assign dbg_tx_beat_count      = tx_cnt_q;
    assign dbg_credit_stall_count = stall_cnt_q;
    assign dbg_fcp_stale_count    = stale_cnt_q;

endmodule

// File: tb/tb_fcp_credit_tx_gate.sv
// Self-checking bench for fcp_credit_tx_gate with small credits and 8-bit
// statistics. It holds a cycle-level reference model of the credit rules
// and checks forwarded beats against a scoreboard queue.
module tb_fcp_credit_tx_gate;

    localparam int QIW = 4;
    localparam int DW  = 64;
    localparam int SW  = 8;
    localparam int IC  = 4;
    localparam int NVC = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   s_tdata;
    logic            s_tvalid, s_tlast, s_tready;
    logic [DW/8-1:0] s_tkeep;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid, m_tlast, m_tready;
    logic [DW/8-1:0] m_tkeep;
    logic            fcp_valid;
    logic [QIW-1:0]  fcp_vc;
    logic [SW-1:0]   fcp_fccl;
    logic [SW-1:0]   dbg_tx, dbg_stall, dbg_stale;

    fcp_credit_tx_gate #(
        .QUEUE_INDEX_WIDTH(QIW), .DATA_WIDTH(DW), .STAT_WIDTH(SW), .INIT_CREDIT(IC)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_pkt_tdata(s_tdata), .s_axis_pkt_tvalid(s_tvalid),
        .s_axis_pkt_tlast(s_tlast), .s_axis_pkt_tkeep(s_tkeep),
        .s_axis_pkt_tready(s_tready),
        .m_axis_pkt_tdata(m_tdata), .m_axis_pkt_tvalid(m_tvalid),
        .m_axis_pkt_tlast(m_tlast), .m_axis_pkt_tkeep(m_tkeep),
        .m_axis_pkt_tready(m_tready),
        .fcp_valid(fcp_valid), .fcp_vc(fcp_vc), .fcp_fccl(fcp_fccl),
        .dbg_tx_beat_count(dbg_tx), .dbg_credit_stall_count(dbg_stall),
        .dbg_fcp_stale_count(dbg_stale)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_fwd    = 0;
    bit rand_rdy = 1'b0;

    typedef struct {
        logic [DW-1:0]   d;
        logic            l;
        logic [DW/8-1:0] k;
    } beat_t;
    beat_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: credits per VC, packet position, output slot and counters.
    int m_fccl[NVC];
    int m_fctbs[NVC];
    bit m_body;
    int m_vcreg;
    bit m_oval;
    int m_tx, m_stall, m_stale;
    int mv, mavail, mdiff;
    bit mok, mordy, macc;

    task automatic model_reset();
        for (int v = 0; v < NVC; v++) begin
            m_fccl[v]  = IC;
            m_fctbs[v] = 0;
        end
        m_body = 0; m_vcreg = 0; m_oval = 0;
        m_tx = 0; m_stall = 0; m_stale = 0;
    endtask

    // Model step: inputs are stable at the falling edge; predict the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            model_reset();
            exp_q.delete();
        end else begin
            mv     = m_body ? m_vcreg : int'(s_tdata[19:16]);
            mavail = (m_fccl[mv] - m_fctbs[mv]) & 255;
            mok    = (mavail != 0) && (mavail < 128);
            mordy  = m_tready || !m_oval;
            macc   = s_tvalid && mok && mordy;
            chk("s_tready", s_tready, mok && mordy);
            chk("m_tvalid", m_tvalid, m_oval);
            chk("tx_count", dbg_tx, m_tx);
            chk("stall_count", dbg_stall, m_stall);
            chk("stale_count", dbg_stale, m_stale);
            if (s_tvalid && !mok && mordy) m_stall = (m_stall + 1) & 255;
            if (macc) begin
                exp_q.push_back('{s_tdata, s_tlast, s_tkeep});
                m_fctbs[mv] = (m_fctbs[mv] + 1) & 255;
                m_tx = (m_tx + 1) & 255;
                m_oval = 1;
                if (!m_body && !s_tlast) begin
                    m_body = 1; m_vcreg = mv;
                end else if (m_body && s_tlast) begin
                    m_body = 0;
                end
            end else if (m_oval && m_tready) begin
                m_oval = 0;
            end
            if (fcp_valid) begin
                mdiff = (int'(fcp_fccl) - m_fccl[fcp_vc]) & 255;
                if (mdiff < 128) m_fccl[fcp_vc] = int'(fcp_fccl);
                else m_stale = (m_stale + 1) & 255;
            end
        end
    end

    // Monitor: every presented output beat must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && m_tvalid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_unexpected: got beat %0h expected none at %0t", m_tdata, $time);
            end else begin
                chk("out_tdata", m_tdata, exp_q[0].d);
                chk("out_tlast", m_tlast, exp_q[0].l);
                chk("out_tkeep", m_tkeep, exp_q[0].k);
                if (m_tready) begin
                    void'(exp_q.pop_front());
                    n_fwd++;
                end
            end
        end
    end

    // Random downstream readiness while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_beat(input logic [3:0] vcf, input bit last);
        logic [DW-1:0] d;
        d = {$urandom, $urandom};
        d[19:16] = vcf;
        s_tdata  = d;
        s_tlast  = last;
        s_tkeep  = 8'($urandom);
        s_tvalid = 1'b1;
    endtask

    task automatic wait_accept(input string name, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            got = s_tready;
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got no accept expected accept within %0d cycles", name, budget);
        end
    endtask

    task automatic expect_stall(input string name, input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            chk(name, s_tready, 1'b0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pkt(input logic [3:0] vcv, input int len);
        for (int b = 0; b < len; b++) begin
            drive_beat((b == 0) ? vcv : 4'($urandom_range(0, 15)), b == len - 1);
            wait_accept("pkt_beat", 200);
        end
    endtask

    task automatic fcp(input logic [3:0] vcv, input logic [SW-1:0] val);
        fcp_valid = 1'b1;
        fcp_vc    = vcv;
        fcp_fccl  = val;
        @(posedge clk);
        #1;
        fcp_valid = 1'b0;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((exp_q.size() != 0 || m_tvalid) && i < 200) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (i >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d beats pending expected 0", exp_q.size());
        end
    endtask

    task automatic fixed_ready(input bit v);
        rand_rdy = 1'b0;
        m_tready = v;
    endtask

    int fwd0, tx0, sent, len;

    initial begin
        rst = 1'b1;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tkeep = '0;
        m_tready = 1'b1;
        fcp_valid = 1'b0; fcp_vc = '0; fcp_fccl = '0;
        idle(3);
        rst = 1'b0;
        idle(1);
        chk("reset_tready", s_tready, 1'b1);
        chk("reset_mvalid", m_tvalid, 1'b0);
        chk("reset_mdata", m_tdata, 64'h0);
        chk("reset_tx", dbg_tx, 8'h0);

        // Credit exhaustion on VC0, then refill to 6.
        for (int i = 0; i < 4; i++) begin
            drive_beat(4'd0, 1'b1);
            wait_accept("a_credit_beat", 5);
        end
        drive_beat(4'd0, 1'b1);
        expect_stall("a_stall_tready", 5);
        chk("a_stall_count", dbg_stall, 8'd5);
        chk("a_fwd_before_fcp", n_fwd, 4);
        fcp(4'd0, 8'd6);
        wait_accept("a_beat5", 5);
        drive_beat(4'd0, 1'b1);
        wait_accept("a_beat6", 5);
        drive_beat(4'd0, 1'b1);
        expect_stall("a_vc0_exhausted", 2);
        s_tvalid = 1'b0;
        idle(3);
        chk("a_tx_count", dbg_tx, 8'd6);
        chk("a_fwd_total", n_fwd, 6);

        // Stale FCP on VC3: the backwards update must be ignored.
        fcp(4'd3, 8'd10);
        fcp(4'd3, 8'd8);
        idle(1);
        chk("b_stale_count", dbg_stale, 8'd1);
        rand_rdy = 1'b1;
        send_pkt(4'd3, 5);
        send_pkt(4'd3, 5);
        fixed_ready(1'b1);
        drain();
        chk("b_fwd_total", n_fwd, 16);
        drive_beat(4'd3, 1'b1);
        expect_stall("b_vc3_exhausted", 2);
        s_tvalid = 1'b0;

        // Mid-packet stall on VC2; body beats carry VC field 7.
        drive_beat(4'd2, 1'b1); wait_accept("c_pre1", 5);
        drive_beat(4'd2, 1'b1); wait_accept("c_pre2", 5);
        drive_beat(4'd2, 1'b0); wait_accept("c_head", 5);
        drive_beat(4'd7, 1'b0); wait_accept("c_body", 5);
        drive_beat(4'd7, 1'b1);
        expect_stall("c_mid_stall", 4);
        fcp(4'd2, 8'd5);
        wait_accept("c_last", 5);
        drive_beat(4'd2, 1'b1);
        expect_stall("c_vc2_exhausted", 2);
        s_tvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_beat(4'd7, 1'b1);
            wait_accept("c_vc7_untouched", 5);
        end
        drive_beat(4'd7, 1'b1);
        expect_stall("c_vc7_exhausted", 2);
        s_tvalid = 1'b0;
        drain();

        // Backpressure: output beat held for 5 cycles, one accept only.
        fixed_ready(1'b0);
        tx0 = int'(dbg_tx);
        drive_beat(4'd4, 1'b1);
        wait_accept("d_first", 5);
        drive_beat(4'd4, 1'b1);
        expect_stall("d_hold_tready", 5);
        chk("d_tx_one", dbg_tx, 8'(tx0 + 1));
        m_tready = 1'b1;
        wait_accept("d_second", 5);
        drain();
        chk("d_tx_two", dbg_tx, 8'(tx0 + 2));

        // Wrap: 300 beats on VC1 with 8-bit counters.
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        fwd0 = n_fwd;
        rand_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            fcp(4'd1, 8'((k * 50 + 100) & 255));
            sent = 0;
            while (sent < 50) begin
                len = $urandom_range(1, 8);
                if (len > 50 - sent) len = 50 - sent;
                send_pkt(4'd1, len);
                sent += len;
            end
        end
        fixed_ready(1'b1);
        drain();
        chk("e_tx_wrap", dbg_tx, 8'd44);
        chk("e_stale_zero", dbg_stale, 8'd0);
        chk("e_fwd_300", n_fwd - fwd0, 300);

        // Reset in the middle of a VC5 packet.
        drive_beat(4'd5, 1'b1); wait_accept("f_pre", 5);
        drive_beat(4'd5, 1'b0); wait_accept("f_head", 5);
        drive_beat(4'd9, 1'b0); wait_accept("f_body", 5);
        m_tready = 1'b0;
        idle(1);
        rst = 1'b1;
        #1;
        chk("f_rst_mvalid", m_tvalid, 1'b0);
        chk("f_rst_mdata", m_tdata, 64'h0);
        chk("f_rst_mlast", m_tlast, 1'b0);
        chk("f_rst_mkeep", m_tkeep, 8'h0);
        chk("f_rst_tx", dbg_tx, 8'h0);
        chk("f_rst_tready", s_tready, 1'b1);
        idle(2);
        rst = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_beat(4'd5, 1'b1);
            wait_accept("f_vc5_fresh", 5);
        end
        drive_beat(4'd5, 1'b1);
        expect_stall("f_vc5_exhausted", 2);
        s_tvalid = 1'b0;
        drain();
        chk("f_tx_after", dbg_tx, 8'd4);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
